// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg: shared FIFO defaults, arbiter state encoding and clog2 helper.
package fifo_wr_arb_pkg;
    localparam int FIFO_DSIZE = 8;
    localparam int FIFO_ASIZE = 4;
    typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick: combinational round-robin search starting just after the last winner.
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   pick,
    output logic            any_req
);
    logic [IW-1:0] idx;
    // Walk from farthest to nearest so the nearest set request wins.
    always_comb begin
        pick = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (req[idx]) pick = idx;
        end
    end
    assign any_req = |req;
endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin, burst-bounded scheduler sharing the FIFO write port.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE,
    parameter int NREQ = 4,
    parameter int MAXBURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic                  wfull,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       gnt,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic                  busy
);
    localparam int IW = clog2(NREQ);
    localparam int BW = clog2(MAXBURST + 1);
    state_t state, state_nxt;
    logic [IW-1:0] owner, last, pick;
    logic [BW-1:0] bcnt;
    logic any_req;
    logic [DSIZE-1:0] slices [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign slices[i] = req_data[i*DSIZE +: DSIZE];
    end
    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req(req),
        .last(last),
        .pick(pick),
        .any_req(any_req)
    );
    // winc is combinational on wfull so a full FIFO blocks the write in the same cycle.
    always_comb begin
        state_nxt = state;
        busy = state == ST_BURST;
        gnt = '0;
        ack = '0;
        winc = 1'b0;
        wdata = '0;
        if (busy) begin
            gnt[owner] = 1'b1;
            wdata = slices[owner];
            winc = req[owner] & ~wfull;
            ack[owner] = winc;
            if (!req[owner] || (winc && bcnt == BW'(MAXBURST - 1))) state_nxt = ST_IDLE;
        end else if (any_req) begin
            state_nxt = ST_BURST;
        end
    end
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state <= ST_IDLE;
            owner <= '0;
            last <= IW'(NREQ - 1);
            bcnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) begin
                owner <= pick;
                last <= pick;
                bcnt <= '0;
            end else if (winc) begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed checks of reset, bursts, rotation, back-pressure and aborts.
module tb_fifo_wr_arb;
    localparam int DSIZE = 8;
    localparam int NREQ = 4;
    localparam int MAXBURST = 4;
    logic wclk = 1'b0;
    logic wrst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic wfull = 1'b0;
    logic [DSIZE-1:0] d [NREQ];
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0] ack, gnt;
    logic winc, busy;
    logic [DSIZE-1:0] wdata;
    int n_chk = 0;
    int n_fail = 0;

    assign req_data = {d[3], d[2], d[1], d[0]};
    always #5 wclk = ~wclk;

    fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
        .wclk(wclk),
        .wrst(wrst),
        .req(req),
        .req_data(req_data),
        .wfull(wfull),
        .ack(ack),
        .gnt(gnt),
        .winc(winc),
        .wdata(wdata),
        .busy(busy)
    );

    task automatic next_cycle;
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset;
        next_cycle;
        wrst = 1'b1;
        req = '0;
        wfull = 1'b0;
        next_cycle;
        wrst = 1'b0;
    endtask

    task automatic test_reset;
        wrst = 1'b1;
        req = 4'b1111;
        wfull = 1'b0;
        for (int i = 0; i < NREQ; i++) d[i] = 8'(8'hA0 + i);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++;
            if (winc !== 1'b0 || ack !== 4'b0 || gnt !== 4'b0 || busy !== 1'b0 || wdata !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold: winc=%b ack=%b gnt=%b busy=%b wdata=%h, expected all zero", winc, ack, gnt, busy, wdata);
            end
            next_cycle;
        end
        wrst = 1'b0;
        #1;
        n_chk++;
        if (winc !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: winc=%b gnt=%b busy=%b, expected 0 0000 0", winc, gnt, busy);
        end
        next_cycle;
        #1;
        n_chk++;
        if (gnt !== 4'b0001 || winc !== 1'b1 || ack !== 4'b0001 || wdata !== 8'hA0) begin
            n_fail++;
            $display("FAIL reset_first_grant: gnt=%b winc=%b ack=%b wdata=%h, expected 0001 1 0001 a0", gnt, winc, ack, wdata);
        end
    endtask

    task automatic test_single;
        int writes;
        logic acked, exp;
        do_reset;
        d[2] = 8'h10;
        req = 4'b0100;
        writes = 0;
        for (int c = 0; c < 11; c++) begin
            #1;
            exp = (c % 5) != 0;
            n_chk++;
            if (winc !== exp) begin
                n_fail++;
                $display("FAIL single_winc c=%0d: winc=%b, expected %b", c, winc, exp);
            end
            if (winc === 1'b1) begin
                n_chk++;
                if (wdata !== 8'(8'h10 + writes) || ack !== 4'b0100 || gnt !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL single_word %0d: wdata=%h ack=%b gnt=%b, expected %h 0100 0100", writes, wdata, ack, gnt, 8'(8'h10 + writes));
                end
                writes++;
            end
            acked = winc;
            next_cycle;
            if (acked) begin
                d[2] = d[2] + 8'h01;
                if (d[2] == 8'h18) req = '0;
            end
        end
        n_chk++;
        if (writes != 8) begin
            n_fail++;
            $display("FAIL single_count: writes=%0d, expected 8", writes);
        end
    endtask

    task automatic test_round_robin;
        int writes, own;
        logic acked, exp;
        logic [NREQ-1:0] ack_s;
        do_reset;
        for (int i = 0; i < NREQ; i++) d[i] = 8'(8'h20 + 16 * i);
        req = 4'b1111;
        writes = 0;
        for (int c = 0; c < 25; c++) begin
            #1;
            exp = (c % 5) != 0;
            n_chk++;
            if (winc !== exp) begin
                n_fail++;
                $display("FAIL rr_winc c=%0d: winc=%b, expected %b", c, winc, exp);
            end
            if (winc === 1'b1) begin
                own = (writes / 4) % 4;
                n_chk++;
                if (ack !== 4'(1 << own) || gnt !== 4'(1 << own) || wdata !== d[own]) begin
                    n_fail++;
                    $display("FAIL rr_order write %0d: ack=%b gnt=%b wdata=%h, expected owner %0d data %h", writes, ack, gnt, wdata, own, d[own]);
                end
                writes++;
            end
            acked = winc;
            ack_s = ack;
            next_cycle;
            if (acked) for (int i = 0; i < NREQ; i++) if (ack_s[i]) d[i] = d[i] + 8'h01;
        end
        n_chk++;
        if (writes != 20) begin
            n_fail++;
            $display("FAIL rr_count: writes=%0d, expected 20", writes);
        end
    endtask

    task automatic test_back_pressure;
        int writes;
        logic acked, exp;
        do_reset;
        req = 4'b0010;
        d[1] = 8'h30;
        writes = 0;
        for (int c = 0; c < 11; c++) begin
            wfull = (c >= 3 && c <= 7);
            #1;
            exp = (c == 1 || c == 2 || c == 8 || c == 9);
            n_chk++;
            if (winc !== exp) begin
                n_fail++;
                $display("FAIL bp_winc c=%0d: winc=%b, expected %b", c, winc, exp);
            end
            if (wfull) begin
                n_chk++;
                if (ack !== 4'b0 || gnt !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL bp_stall c=%0d: ack=%b gnt=%b, expected 0000 0010", c, ack, gnt);
                end
            end
            if (winc === 1'b1) begin
                n_chk++;
                if (wdata !== 8'(8'h30 + writes) || ack !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL bp_word %0d: wdata=%h ack=%b, expected %h 0010", writes, wdata, ack, 8'(8'h30 + writes));
                end
                writes++;
            end
            if (c == 10) begin
                n_chk++;
                if (gnt !== 4'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_end_idle: gnt=%b busy=%b, expected 0000 0", gnt, busy);
                end
            end
            acked = winc;
            next_cycle;
            if (acked) d[1] = d[1] + 8'h01;
        end
        wfull = 1'b0;
        n_chk++;
        if (writes != 4) begin
            n_fail++;
            $display("FAIL bp_count: writes=%0d, expected 4", writes);
        end
    endtask

    task automatic test_early_release;
        do_reset;
        d[2] = 8'h70;
        d[3] = 8'h80;
        req = 4'b1100;
        #1;
        n_chk++;
        if (gnt !== 4'b0 || winc !== 1'b0) begin
            n_fail++;
            $display("FAIL early_idle0: gnt=%b winc=%b, expected 0000 0", gnt, winc);
        end
        next_cycle;
        #1;
        n_chk++;
        if (gnt !== 4'b0100 || winc !== 1'b1 || ack !== 4'b0100 || wdata !== 8'h70) begin
            n_fail++;
            $display("FAIL early_first: gnt=%b winc=%b ack=%b wdata=%h, expected 0100 1 0100 70", gnt, winc, ack, wdata);
        end
        next_cycle;
        req = 4'b1000;
        #1;
        n_chk++;
        if (winc !== 1'b0 || ack !== 4'b0) begin
            n_fail++;
            $display("FAIL early_drop: winc=%b ack=%b, expected 0 0000", winc, ack);
        end
        next_cycle;
        #1;
        n_chk++;
        if (busy !== 1'b0 || gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL early_to_idle: busy=%b gnt=%b, expected 0 0000", busy, gnt);
        end
        next_cycle;
        #1;
        n_chk++;
        if (gnt !== 4'b1000 || winc !== 1'b1 || wdata !== 8'h80) begin
            n_fail++;
            $display("FAIL early_next_owner: gnt=%b winc=%b wdata=%h, expected 1000 1 80", gnt, winc, wdata);
        end
    endtask

    task automatic test_reset_mid_burst;
        do_reset;
        req = 4'b0010;
        d[0] = 8'h50;
        d[1] = 8'h66;
        next_cycle;
        #1;
        n_chk++;
        if (winc !== 1'b1 || wdata !== 8'h66) begin
            n_fail++;
            $display("FAIL abort_pre_write: winc=%b wdata=%h, expected 1 66", winc, wdata);
        end
        #1;
        wrst = 1'b1;
        #1;
        n_chk++;
        if (winc !== 1'b0 || gnt !== 4'b0 || ack !== 4'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: winc=%b gnt=%b ack=%b busy=%b, expected 0 0000 0000 0", winc, gnt, ack, busy);
        end
        next_cycle;
        wrst = 1'b0;
        req = 4'b0011;
        for (int c = 0; c < 7; c++) begin
            #1;
            if (c == 1) begin
                n_chk++;
                if (gnt !== 4'b0001 || winc !== 1'b1 || wdata !== 8'h50) begin
                    n_fail++;
                    $display("FAIL abort_restart0: gnt=%b winc=%b wdata=%h, expected 0001 1 50", gnt, winc, wdata);
                end
            end
            if (c == 6) begin
                n_chk++;
                if (ack !== 4'b0010 || winc !== 1'b1 || wdata !== 8'h66) begin
                    n_fail++;
                    $display("FAIL abort_replay: ack=%b winc=%b wdata=%h, expected 0010 1 66", ack, winc, wdata);
                end
            end
            next_cycle;
        end
        req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_back_pressure;
        test_early_release;
        test_reset_mid_burst;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
